// File: rtl/lcd_nibble_rx_if.sv
// 4-bit HD44780-style LCD bus: E strobe, RS, RW and DB[7:4].
// The driver side is the master; the receiver model is the slave.
interface lcd_nibble_rx_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_data;

  modport master (output lcd_en, output lcd_rs, output lcd_rw, output lcd_data);
  modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd_nibble_rx.sv
// Receiver/model for the 4-bit LCD bus: reassembles nibbles into bytes,
// executes instructions into display-state registers and keeps a DDRAM image.
//
// state  | meaning
// S_FILL | writing FILL_CHAR to cells 0..DEPTH-1, one per cycle; busy=1
// S_IDLE | executing assembled bytes as they arrive
module lcd_nibble_rx #(
  parameter int          DEPTH     = 80,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic             clk_LCD,
  input  logic             rst_n,
  lcd_nibble_rx_if.slave   bus,
  output logic             byte_valid,
  output logic             byte_rs,
  output logic [7:0]       byte_data,
  output logic             busy,
  output logic [6:0]       ac,
  output logic             disp_on,
  output logic             cursor_on,
  output logic             blink_on,
  output logic             entry_id,
  output logic             entry_s,
  output logic             func_n,
  output logic             func_f,
  output logic             rw_err,
  output logic             ovr_err,
  output logic             dl_err,
  input  logic [6:0]       rd_addr,
  output logic [7:0]       rd_data
);

  typedef enum logic {S_FILL, S_IDLE} state_t;

  localparam logic [6:0] LAST    = 7'(DEPTH - 1);
  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  state_t     state, state_nx;
  logic       en_s1, en_s2, en_s3;
  logic       rs_s1, rs_s2, rw_s1, rw_s2;
  logic [3:0] d_s1, d_s2;
  logic       fall;
  logic       phase_lsb;
  logic [3:0] hi_nib;
  logic       cap_valid, cap_rs;
  logic [7:0] cap_byte;
  logic [6:0] fill_cnt;
  logic       fill_last, exec;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] ddram [DEPTH];

  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    if (up) return (a == LAST) ? 7'd0 : a + 7'd1;
    else    return (a == 7'd0) ? LAST : a - 7'd1;
  endfunction

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      en_s1 <= 1'b0; en_s2 <= 1'b0; en_s3 <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      d_s1  <= '0;   d_s2  <= '0;
    end else begin
      en_s1 <= bus.lcd_en;   en_s2 <= en_s1; en_s3 <= en_s2;
      rs_s1 <= bus.lcd_rs;   rs_s2 <= rs_s1;
      rw_s1 <= bus.lcd_rw;   rw_s2 <= rw_s1;
      d_s1  <= bus.lcd_data; d_s2  <= d_s1;
    end
  end

  assign fall = en_s3 & ~en_s2;

  // A read strobe is flagged and dropped without disturbing the nibble phase.
  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      phase_lsb <= 1'b0;
      hi_nib    <= '0;
      cap_valid <= 1'b0;
      cap_rs    <= 1'b0;
      cap_byte  <= '0;
      rw_err    <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if (fall) begin
        if (rw_s2) begin
          rw_err <= 1'b1;
        end else if (!phase_lsb) begin
          hi_nib    <= d_s2;
          phase_lsb <= 1'b1;
        end else begin
          cap_valid <= 1'b1;
          cap_byte  <= {hi_nib, d_s2};
          cap_rs    <= rs_s2;
          phase_lsb <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= cap_valid;
      if (cap_valid) begin
        byte_rs   <= cap_rs;
        byte_data <= cap_byte;
      end
    end
  end

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    fill_last = 1'b0;
    exec      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ac;
    mem_wdata = cap_byte;
    case (state)
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = fill_cnt;
        mem_wdata = FILL_CHAR;
        if (fill_cnt == LAST) begin
          fill_last = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cap_valid) begin
          exec = 1'b1;
          if (cap_rs)                  mem_we   = 1'b1;
          else if (cap_byte == 8'h01)  state_nx = S_FILL;
        end
      end
      default: state_nx = S_FILL;
    endcase
  end

  assign busy = (state == S_FILL);

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      ac        <= '0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      entry_id  <= 1'b1;
      entry_s   <= 1'b0;
      func_n    <= 1'b0;
      func_f    <= 1'b0;
      dl_err    <= 1'b0;
      ovr_err   <= 1'b0;
    end else if (state == S_FILL) begin
      fill_cnt <= fill_cnt + 7'd1;
      if (cap_valid) ovr_err <= 1'b1;
      if (fill_last) begin
        fill_cnt <= '0;
        ac       <= '0;
        entry_id <= 1'b1;
      end
    end else if (exec) begin
      if (cap_rs) begin
        ac <= step(ac, entry_id);
      end else begin
        casez (cap_byte)
          8'b1???????: ac <= ({1'b0, cap_byte[6:0]} < DEPTH_W) ? cap_byte[6:0] : 7'd0;
          8'b01??????: ;
          8'b001?????: begin
            func_n <= cap_byte[3];
            func_f <= cap_byte[2];
            if (cap_byte[4]) dl_err <= 1'b1;
          end
          8'b0001????: if (!cap_byte[3]) ac <= step(ac, cap_byte[2]);
          8'b00001???: begin
            disp_on   <= cap_byte[2];
            cursor_on <= cap_byte[1];
            blink_on  <= cap_byte[0];
          end
          8'b000001??: begin
            entry_id <= cap_byte[1];
            entry_s  <= cap_byte[0];
          end
          8'b0000001?: ac <= '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_LCD) begin
    if (mem_we) ddram[mem_addr] <= mem_wdata;
  end

  // Registered read sees the pre-write contents of a cell written this cycle.
  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= ({1'b0, rd_addr} < DEPTH_W) ? ddram[rd_addr] : FILL_CHAR;
  end

endmodule

// File: doc/lcd_nibble_rx.md
Name: lcd_nibble_rx

Overview:
- Receiving end of the HD44780-style 4-bit parallel LCD bus that the LCD driver FSM produces.
- Samples E/RS/RW/DB[7:4] and reassembles the nibbles into bytes.
- Decodes instruction bytes into display-state registers and writes data bytes into a local DDRAM image with an address counter.
- Serves as a synthesizable bus monitor and LCD model for on-chip loopback and simulation.

Parameters:
DEPTH, 80, number of DDRAM character cells (valid addresses 0..DEPTH-1, DEPTH <= 128)
FILL_CHAR, 8'h20, value written to every cell on reset and on Clear Display

Ports:
clk_LCD  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
lcd_en  input  1  bus E strobe, asynchronous to clk_LCD
lcd_rs  input  1  bus RS (0 instruction, 1 data)
lcd_rw  input  1  bus RW (0 write, 1 read)
lcd_data  input  4  bus DB[7:4]
byte_valid  output  1  one-cycle pulse when a byte is assembled
byte_rs  output  1  RS of assembled byte
byte_data  output  8  assembled byte
busy  output  1  fill sequence in progress
ac  output  7  DDRAM address counter
disp_on, cursor_on, blink_on  output  1 each  Display Control D/C/B bits
entry_id, entry_s  output  1 each  Entry Mode I/D and S bits
func_n, func_f  output  1 each  Function Set N and F bits
rw_err  output  1  sticky: strobe seen with lcd_rw=1
ovr_err  output  1  sticky: byte arrived while busy
dl_err  output  1  sticky: Function Set with DL=1 received
rd_addr  input  7  DDRAM read address
rd_data  output  8  DDRAM[rd_addr], registered, 1-cycle latency; FILL_CHAR when rd_addr >= DEPTH

Behaviour:
- Reset values:
  - byte_valid=0, byte_rs=0, byte_data=0, ac=0.
  - disp_on=0, cursor_on=0, blink_on=0, entry_id=1, entry_s=0, func_n=0, func_f=0.
  - All error flags 0, rd_data=0, nibble phase=MSB.
  - busy=1 and the fill sequence starts.
- Sampling:
  - lcd_en, lcd_rs, lcd_rw and lcd_data pass through 2-flop synchronizers; a third register on en provides edge detection.
  - A nibble is captured on a detected falling edge of E, using the synchronized RS/RW/data of that cycle.
  - If the first clk_LCD edge sampling en=0 is edge N, detection occurs at edge N+2.
  - Minimum E high and low widths are 2 clk_LCD cycles each; narrower pulses are not guaranteed.
- Nibble assembly:
  - Phase MSB: store nibble as byte[7:4], go to phase LSB.
  - Phase LSB: byte[3:0]=nibble; byte_valid pulses at edge N+3 with byte_rs = RS sampled on the LSB nibble; go to phase MSB.
  - RS mismatch between the two nibbles: the LSB nibble's RS wins.
  - Strobe with RW=1: set rw_err, nibble ignored, phase unchanged.
- Fill sequence (state FILL):
  - Writes FILL_CHAR to cells 0..DEPTH-1, one per cycle, DEPTH cycles total; busy=1 throughout.
  - On exit: ac=0, entry_id=1, state IDLE.
  - Bytes completing while busy still pulse byte_valid but are not executed; ovr_err is set.
- Instruction decode (byte_rs=0, IDLE only; first match from MSB):
  - 1aaaaaaa: ac = a if a < DEPTH, else ac = 0.
  - 01xxxxxx: CGRAM address, ignored.
  - 001D NFxx: func_n=N, func_f=F; if D=1 set dl_err (receiver stays in 4-bit mode).
  - 0001 S R xx: if S=0, ac moves +1 (R=1) or -1 (R=0) with wrap; if S=1, no action.
  - 00001DCB: disp_on/cursor_on/blink_on = D/C/B.
  - 000001IS: entry_id=I, entry_s=S.
  - 0000001x: ac=0.
  - 00000001: enter FILL (same sequence as reset).
  - 00000000: no action.
- Data write (byte_rs=1, IDLE):
  - DDRAM[ac] <= byte_data, then ac advances by entry_id (1:+1, 0:-1).
  - Wrap: DEPTH-1 -> 0 on increment, 0 -> DEPTH-1 on decrement.
  - entry_s has no effect on storage.
- Every executed byte completes in a single cycle; busy never asserts except in FILL.
- Read port: rd_data updates every cycle from rd_addr. Reading the cell being written in the same cycle returns the old value.
- Reset mid-operation (during FILL or between nibbles): everything returns to reset values, phase returns to MSB, and FILL restarts from cell 0.
- Error flags are cleared only by reset.

Test Plan:
- Reset release -> busy=1 for exactly DEPTH=80 cycles, then 0; reading addresses 0, 40, 79 returns 8'h20 and address 100 returns 8'h20; ac=0.
- Nibbles 0,1 / 2,0 / 0,C / 0,6 with RS=0, then 4,B,6,1,7,0,7,0,6,1 with RS=1 -> after the Clear fill completes, the data bytes store "Kappa" (4B 61 70 70 61) at cells 0..4; final state ac=5, disp_on=1, cursor_on=0, blink_on=0, entry_id=1, func_n=0.
- Entry mode 0x04, set address 0x80, write 0x41 -> cell 0 = 0x41 and ac wraps to 79; instruction 0xCF (address 79) -> ac=79 (<DEPTH); instruction 0xD0 (address 80 >= DEPTH) -> ac=0.
- Strobe with RW=1 between MSB and LSB nibbles of 0x48 -> rw_err=1 and byte still assembles as 0x48 with one byte_valid pulse; a byte sent during busy -> ovr_err=1 and DDRAM unchanged.
- Function Set byte 0x38 -> dl_err=1, func_n=1, func_f=0; the next nibble pair still assembles correctly.
- Assert rst_n low after only the MSB nibble of a byte -> after release the next two nibbles form one byte (phase reset to MSB), and FILL reruns for 80 cycles.
